conv_frame_streamer: RTL and testbench
======================================

CONV_FRAME_STREAMER -- requirements
Module: conv_frame_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 SHALL have parameter BUFFER_LENGTH, default 2000: max frame columns; column count width = $clog2(BUFFER_LENGTH).
REQ-003 SHALL have parameter MAX_ROWS, default 2000: max frame rows; row count width = $clog2(MAX_ROWS).
REQ-004 SHALL have parameter ADDR_WIDTH, default 22: frame RAM address width.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port start, input, 1 bit: one-cycle request to stream one frame.
REQ-008 SHALL have port frame_column_size, input, $clog2(BUFFER_LENGTH) bits: columns per row.
REQ-009 SHALL have port frame_row_size, input, $clog2(MAX_ROWS) bits: rows per frame.
REQ-010 SHALL have port base_addr, input, ADDR_WIDTH bits: RAM address of pixel (0,0).
REQ-011 SHALL have port stall, input, 1 bit: downstream cannot accept a pixel this cycle.
REQ-012 SHALL have port mem_en, output, 1 bit: frame RAM read enable.
REQ-013 SHALL have port mem_addr, output, ADDR_WIDTH bits: frame RAM read address.
REQ-014 SHALL have port mem_rdata, input, DATA_WIDTH bits: RAM read data, valid exactly 1 cycle after mem_en.
REQ-015 SHALL have port out_point, output, DATA_WIDTH bits: pixel to conv line buffer (its in_point).
REQ-016 SHALL have port valid_out, output, 1 bit: out_point valid (drives line buffer valid_in, gated by stall externally).
REQ-017 SHALL have ports last_col and last_pixel, output, 1 bit each: current pixel ends a row / ends the frame.
REQ-018 SHALL have ports busy and done, output, 1 bit each: frame in progress / one-cycle completion pulse.

Function
REQ-019 SHALL implement FSM IDLE -> STREAM -> DRAIN -> DONE -> IDLE; busy=1 in STREAM and DRAIN.
REQ-020 SHALL, in IDLE with start=1, latch sizes and base_addr and enter STREAM; start outside IDLE SHALL be ignored.
REQ-021 SHALL, if latched column or row size is 0 at start, go IDLE -> DONE with no mem_en and no valid_out.
REQ-022 SHALL issue reads in raster order, mem_addr = base_addr + row*frame_column_size + col, via an incrementing address counter (no multiplier), wrapping modulo 2^ADDR_WIDTH.
REQ-023 SHALL buffer returned data in a 2-entry FIFO; each entry carries pixel, last_col, last_pixel tags.
REQ-024 SHALL assert valid_out iff FIFO non-empty; out_point/tags = FIFO head; pop when valid_out=1 and stall=0.
REQ-025 SHALL assert mem_en in STREAM only when (FIFO count + reads in flight - pop this cycle) < 2, guaranteeing no overflow and no lost pixel under any stall pattern.
REQ-026 SHALL sustain 1 pixel/cycle while stall=0.
REQ-027 SHALL hold out_point, valid_out and tags stable while stall=1 and valid_out=1.
REQ-028 SHALL make first mem_en the cycle after start is sampled, and first valid_out 2 cycles after first mem_en.
REQ-029 SHALL enter DRAIN after the last read (row_size*column_size reads) is issued; DRAIN -> DONE when FIFO empty and nothing in flight.
REQ-030 SHALL pulse done for exactly one cycle in DONE, then return to IDLE; start in that DONE cycle is ignored.
REQ-031 SHALL keep mem_en=0 outside STREAM.

Reset
REQ-032 SHALL, while rst=1, force state IDLE, FIFO empty, counters 0, and mem_en, mem_addr, valid_out, out_point, last_col, last_pixel, busy, done all 0.
REQ-033 SHALL, on rst mid-frame, drop in-flight and buffered pixels; data returning after rst deassert is discarded.

Verification
REQ-034 3x4 frame (rows=3, cols=4), base=0x100, RAM[a]=a[7:0], stall=0 -> 12 valid_out cycles contiguous, out_point 0x00..0x0B, last_col on 4th/8th/12th, last_pixel on 12th only, done 1 cycle after DRAIN empties.
REQ-035 Same frame, stall random 50% -> identical 12-pixel sequence on popped cycles, no FIFO overflow, outputs stable during stall.
REQ-036 stall held 1 from start for 20 cycles -> exactly 2 reads issued, valid_out=1 with pixel 0 held, then full sequence after release.
REQ-037 start with cols=0 -> no mem_en, no valid_out, done pulse 1 cycle after start, busy stays 0.
REQ-038 rst asserted after 5th pixel popped -> all outputs 0 same cycle; new start afterwards streams from base_addr with pixel 0 first.
REQ-039 start pulsed during STREAM and in DONE cycle -> ignored, exactly one frame streamed.

Source files
------------

// File: rtl/conv_frame_streamer.sv
// Streams one frame from a frame RAM in raster order into the conv line buffer,
// with a 2-entry skid FIFO so a 1-cycle RAM latency never loses pixels under stall.
module conv_frame_streamer #(
  parameter int DATA_WIDTH    = 8,
  parameter int BUFFER_LENGTH = 2000,
  parameter int MAX_ROWS      = 2000,
  parameter int ADDR_WIDTH    = 22
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [$clog2(BUFFER_LENGTH)-1:0] frame_column_size,
  input  logic [$clog2(MAX_ROWS)-1:0]      frame_row_size,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic                             stall,
  output logic                             mem_en,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic [DATA_WIDTH-1:0]            out_point,
  output logic                             valid_out,
  output logic                             last_col,
  output logic                             last_pixel,
  output logic                             busy,
  output logic                             done
);

  localparam int CW = $clog2(BUFFER_LENGTH);
  localparam int RW = $clog2(MAX_ROWS);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t                state, state_next;
  logic [CW-1:0]         col_cnt, col_last_idx;
  logic [RW-1:0]         row_cnt, row_last_idx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  inflight, inflight_lc, inflight_lp;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]            fifo_lc, fifo_lp;
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            fifo_count;
  logic                  push, pop, at_col_end, at_row_end, frame_empty;
  logic [2:0]            occupancy;

  assign at_col_end  = (col_cnt == col_last_idx);
  assign at_row_end  = (row_cnt == row_last_idx);
  assign frame_empty = (frame_column_size == '0) || (frame_row_size == '0);
  assign valid_out   = (fifo_count != 2'd0);
  assign push        = inflight;
  assign pop         = valid_out && !stall;
  // Slots committed once this cycle's pop retires; a new read must fit in the FIFO.
  assign occupancy   = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign out_point   = valid_out ? fifo_data[rd_ptr] : '0;
  assign last_col    = valid_out && fifo_lc[rd_ptr];
  assign last_pixel  = valid_out && fifo_lp[rd_ptr];
  assign mem_addr    = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = frame_empty ? DONE : STREAM;
      STREAM:  if (mem_en && at_col_end && at_row_end) state_next = DRAIN;
      DRAIN:   if (fifo_count == 2'd0 && !inflight) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_en = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      STREAM: begin
        busy   = 1'b1;
        mem_en = (occupancy < 3'd2);
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Raster addresses are contiguous, so a single incrementing pointer replaces row*cols+col.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt      <= '0;
      row_cnt      <= '0;
      col_last_idx <= '0;
      row_last_idx <= '0;
      addr_q       <= '0;
      inflight     <= 1'b0;
      inflight_lc  <= 1'b0;
      inflight_lp  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        col_last_idx <= frame_column_size - CW'(1);
        row_last_idx <= frame_row_size - RW'(1);
        addr_q       <= base_addr;
        col_cnt      <= '0;
        row_cnt      <= '0;
      end else if (mem_en) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        if (at_col_end) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + RW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end
      inflight    <= mem_en;
      inflight_lc <= at_col_end;
      inflight_lp <= at_col_end && at_row_end;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) fifo_data[i] <= '0;
      fifo_lc    <= '0;
      fifo_lp    <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= mem_rdata;
        fifo_lc[wr_ptr]   <= inflight_lc;
        fifo_lp[wr_ptr]   <= inflight_lp;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_streamer.sv
// Directed bench for conv_frame_streamer: 3x4 frame at base 0x100 with a RAM
// returning the low address byte, exercised under several stall/reset/start patterns.
module tb_conv_frame_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] frame_column_size;
  logic [10:0] frame_row_size;
  logic [21:0] base_addr;
  logic        stall;
  logic        mem_en;
  logic [21:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [7:0]  out_point;
  logic        valid_out;
  logic        last_col;
  logic        last_pixel;
  logic        busy;
  logic        done;

  int cmp_count  = 0;
  int fail_count = 0;
  int read_count = 0;

  conv_frame_streamer dut (
    .clk(clk), .rst(rst), .start(start),
    .frame_column_size(frame_column_size), .frame_row_size(frame_row_size),
    .base_addr(base_addr), .stall(stall), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_point(out_point), .valid_out(valid_out),
    .last_col(last_col), .last_pixel(last_pixel), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Frame RAM: RAM[a] = a[7:0], one cycle read latency.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem_addr[7:0];
    if (mem_en) read_count <= read_count + 1;
  end

  task automatic pulse_start(input logic [10:0] cols, input logic [10:0] rows,
                             input logic [21:0] base, input logic hold_stall);
    @(negedge clk);
    frame_column_size = cols;
    frame_row_size    = rows;
    base_addr         = base;
    stall             = hold_stall;
    start             = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    cmp_count++;
    if ({mem_en, mem_addr, valid_out, out_point, last_col, last_pixel, busy, done} !== '0) begin
      fail_count++;
      $display("[TB] FAIL reset_outputs: got en=%b addr=%h v=%b pt=%h lc=%b lp=%b busy=%b done=%b, expected all 0",
               mem_en, mem_addr, valid_out, out_point, last_col, last_pixel, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    cmp_count++;
    if (busy !== 1'b0 || mem_en !== 1'b0 || valid_out !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL reset_idle: got busy=%b en=%b v=%b, expected 0 0 0", busy, mem_en, valid_out);
    end
  endtask

  task automatic test_basic();
    int k = 0;
    int r0 = read_count;
    logic [7:0] exp_pt;
    pulse_start(11'd4, 11'd3, 22'h100, 1'b0);
    for (int c = 0; c < 20; c++) begin
      #1;
      if (c == 0) begin
        cmp_count++;
        if (mem_en !== 1'b1 || mem_addr !== 22'h100) begin
          fail_count++;
          $display("[TB] FAIL basic_first_read: got en=%b addr=%h, expected 1 100", mem_en, mem_addr);
        end
      end
      if (valid_out === 1'b1) begin
        exp_pt = 8'(32'h100 + k);
        cmp_count++;
        if (c != k + 2 || out_point !== exp_pt || last_col !== (k % 4 == 3) || last_pixel !== (k == 11)) begin
          fail_count++;
          $display("[TB] FAIL basic_pixel%0d: got cycle=%0d pt=%h lc=%b lp=%b, expected cycle=%0d pt=%h lc=%b lp=%b",
                   k, c, out_point, last_col, last_pixel, k + 2, exp_pt, (k % 4 == 3), (k == 11));
        end
        k++;
      end
      cmp_count++;
      if (done !== (c == 15) || busy !== (c <= 14)) begin
        fail_count++;
        $display("[TB] FAIL basic_ctrl_c%0d: got done=%b busy=%b, expected done=%b busy=%b",
                 c, done, busy, (c == 15), (c <= 14));
      end
      @(negedge clk);
    end
    cmp_count++;
    if (k != 12 || read_count - r0 != 12) begin
      fail_count++;
      $display("[TB] FAIL basic_counts: got pixels=%0d reads=%0d, expected 12 12", k, read_count - r0);
    end
  endtask

  task automatic test_random_stall();
    int k = 0;
    int r0 = read_count;
    logic prev_hold = 1'b0;
    logic seen_done = 1'b0;
    logic [7:0] exp_pt;
    pulse_start(11'd4, 11'd3, 22'h100, 1'b0);
    for (int c = 0; c < 200 && !seen_done; c++) begin
      stall = 1'($urandom_range(0, 1));
      #1;
      if (prev_hold) begin
        cmp_count++;
        if (valid_out !== 1'b1) begin
          fail_count++;
          $display("[TB] FAIL rand_hold_valid_c%0d: got v=%b, expected 1", c, valid_out);
        end
      end
      if (valid_out === 1'b1) begin
        exp_pt = 8'(32'h100 + k);
        cmp_count++;
        if (out_point !== exp_pt || last_col !== (k % 4 == 3) || last_pixel !== (k == 11)) begin
          fail_count++;
          $display("[TB] FAIL rand_pixel%0d: got pt=%h lc=%b lp=%b, expected pt=%h lc=%b lp=%b",
                   k, out_point, last_col, last_pixel, exp_pt, (k % 4 == 3), (k == 11));
        end
        if (!stall) k++;
      end
      prev_hold = valid_out && stall;
      if (done === 1'b1) seen_done = 1'b1;
      @(negedge clk);
    end
    stall = 1'b0;
    cmp_count++;
    if (!seen_done || k != 12 || read_count - r0 != 12) begin
      fail_count++;
      $display("[TB] FAIL rand_counts: got done=%b pixels=%0d reads=%0d, expected 1 12 12",
               seen_done, k, read_count - r0);
    end
  endtask

  task automatic test_stall_hold();
    int k = 0;
    int r0 = read_count;
    logic seen_done = 1'b0;
    logic [7:0] exp_pt;
    pulse_start(11'd4, 11'd3, 22'h100, 1'b1);
    for (int c = 0; c < 80 && !seen_done; c++) begin
      stall = (c < 20);
      #1;
      if (c == 19) begin
        cmp_count++;
        if (read_count - r0 != 2) begin
          fail_count++;
          $display("[TB] FAIL hold_reads: got %0d, expected 2", read_count - r0);
        end
      end
      if (c >= 2 && c < 20) begin
        cmp_count++;
        if (valid_out !== 1'b1 || out_point !== 8'h00) begin
          fail_count++;
          $display("[TB] FAIL hold_head_c%0d: got v=%b pt=%h, expected 1 00", c, valid_out, out_point);
        end
      end
      if (valid_out === 1'b1) begin
        exp_pt = 8'(32'h100 + k);
        cmp_count++;
        if (out_point !== exp_pt || last_col !== (k % 4 == 3) || last_pixel !== (k == 11)) begin
          fail_count++;
          $display("[TB] FAIL hold_pixel%0d: got pt=%h lc=%b lp=%b, expected pt=%h lc=%b lp=%b",
                   k, out_point, last_col, last_pixel, exp_pt, (k % 4 == 3), (k == 11));
        end
        if (!stall) k++;
      end
      if (done === 1'b1) seen_done = 1'b1;
      @(negedge clk);
    end
    stall = 1'b0;
    cmp_count++;
    if (!seen_done || k != 12 || read_count - r0 != 12) begin
      fail_count++;
      $display("[TB] FAIL hold_counts: got done=%b pixels=%0d reads=%0d, expected 1 12 12",
               seen_done, k, read_count - r0);
    end
  endtask

  task automatic test_zero_size();
    int r0 = read_count;
    pulse_start(11'd0, 11'd3, 22'h100, 1'b0);
    for (int c = 0; c < 6; c++) begin
      #1;
      cmp_count++;
      if (mem_en !== 1'b0 || valid_out !== 1'b0 || busy !== 1'b0 || done !== (c == 0)) begin
        fail_count++;
        $display("[TB] FAIL zero_c%0d: got en=%b v=%b busy=%b done=%b, expected 0 0 0 %b",
                 c, mem_en, valid_out, busy, done, (c == 0));
      end
      @(negedge clk);
    end
    cmp_count++;
    if (read_count != r0) begin
      fail_count++;
      $display("[TB] FAIL zero_reads: got %0d, expected 0", read_count - r0);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    logic seen_done = 1'b0;
    logic [7:0] exp_pt;
    pulse_start(11'd4, 11'd3, 22'h100, 1'b0);
    for (int c = 0; c < 12 && k < 5; c++) begin
      #1;
      if (valid_out === 1'b1) k++;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    cmp_count++;
    if ({mem_en, mem_addr, valid_out, out_point, last_col, last_pixel, busy, done} !== '0) begin
      fail_count++;
      $display("[TB] FAIL midreset_outputs: got en=%b addr=%h v=%b pt=%h lc=%b lp=%b busy=%b done=%b, expected all 0",
               mem_en, mem_addr, valid_out, out_point, last_col, last_pixel, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      cmp_count++;
      if (valid_out !== 1'b0 || busy !== 1'b0) begin
        fail_count++;
        $display("[TB] FAIL midreset_discard_c%0d: got v=%b busy=%b, expected 0 0", c, valid_out, busy);
      end
      @(negedge clk);
    end
    k = 0;
    pulse_start(11'd4, 11'd3, 22'h100, 1'b0);
    for (int c = 0; c < 20; c++) begin
      #1;
      if (c == 0) begin
        cmp_count++;
        if (mem_en !== 1'b1 || mem_addr !== 22'h100) begin
          fail_count++;
          $display("[TB] FAIL restart_first_read: got en=%b addr=%h, expected 1 100", mem_en, mem_addr);
        end
      end
      if (valid_out === 1'b1) begin
        exp_pt = 8'(32'h100 + k);
        cmp_count++;
        if (c != k + 2 || out_point !== exp_pt) begin
          fail_count++;
          $display("[TB] FAIL restart_pixel%0d: got cycle=%0d pt=%h, expected cycle=%0d pt=%h",
                   k, c, out_point, k + 2, exp_pt);
        end
        k++;
      end
      if (done === 1'b1) seen_done = 1'b1;
      @(negedge clk);
    end
    cmp_count++;
    if (!seen_done || k != 12) begin
      fail_count++;
      $display("[TB] FAIL restart_counts: got done=%b pixels=%0d, expected 1 12", seen_done, k);
    end
  endtask

  task automatic test_start_ignored();
    int k = 0;
    int n_done = 0;
    int r0 = read_count;
    pulse_start(11'd4, 11'd3, 22'h100, 1'b0);
    for (int c = 0; c < 25; c++) begin
      start = (c == 3 || c == 15);
      #1;
      if (valid_out === 1'b1) k++;
      if (done === 1'b1) n_done++;
      cmp_count++;
      if (busy !== (c <= 14) || (c >= 12 && mem_en !== 1'b0)) begin
        fail_count++;
        $display("[TB] FAIL ignore_ctrl_c%0d: got busy=%b en=%b, expected busy=%b en=0",
                 c, busy, mem_en, (c <= 14));
      end
      @(negedge clk);
    end
    start = 1'b0;
    cmp_count++;
    if (k != 12 || n_done != 1 || read_count - r0 != 12) begin
      fail_count++;
      $display("[TB] FAIL ignore_counts: got pixels=%0d dones=%0d reads=%0d, expected 12 1 12",
               k, n_done, read_count - r0);
    end
  endtask

  initial begin
    rst               = 1'b1;
    start             = 1'b0;
    stall             = 1'b0;
    frame_column_size = '0;
    frame_row_size    = '0;
    base_addr         = '0;
    test_reset();
    test_basic();
    test_random_stall();
    test_stall_hold();
    test_zero_size();
    test_reset_mid();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
